// File: rtl/ifetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and the
// instruction memory (slave). The fetch unit issues a request with an address
// and the memory answers with a one-cycle ack carrying the instruction word.
interface ifetch_if #(
  parameter int DATASIZE = 16,
  parameter int ADDRSIZE = 11
) ();
  logic                mem_req_o;
  logic [ADDRSIZE-1:0] mem_addr_o;
  logic                mem_ack_i;
  logic [DATASIZE-1:0] mem_data_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: walks the PC through instruction memory, holds one
// fetched instruction for the downstream stage and honours jumps and stalls.
// Optional feature: define IFETCH_TIMEOUT_EN to enable the fetch-timeout
// watchdog (err_o pulses and the request is re-issued after TIMEOUT cycles
// without an ack). Without the macro, err_o is tied low and REQ waits forever.
module ifetch #(
  parameter int DATASIZE    = 16,
  parameter int OPERANDSIZE = 11,
  parameter int ADDRSIZE    = 11,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  ifetch_if.master                        mem,
  input  logic                            pc_load_i,
  input  logic [ADDRSIZE-1:0]             pc_target_i,
  input  logic                            stall_i,
  output logic [DATASIZE-OPERANDSIZE-1:0] opcode_o,
  output logic [OPERANDSIZE-1:0]          operand_o,
  output logic                            valid_o,
  output logic [ADDRSIZE-1:0]             pc_o,
  output logic                            err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state;
  logic [ADDRSIZE-1:0] pc;
  logic [DATASIZE-1:0] ir;
  logic                req_q;
  logic                valid_q;
  logic [ADDRSIZE-1:0] pc_held;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Fetch FSM: PC, instruction register, held-instruction PC and the request flag.
  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values; blocking would make the result depend on statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      pc_held <= '0;
`ifdef IFETCH_TIMEOUT_EN
      to_cnt  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef IFETCH_TIMEOUT_EN
      // err_o is a single-cycle pulse unless re-asserted below.
      err_q <= 1'b0;
`endif
      if (pc_load_i) begin
        // A jump overrides everything: any coincident ack or held instruction is dropped.
        pc      <= pc_target_i;
        state   <= REQ;
        req_q   <= 1'b1;
        valid_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        to_cnt  <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            state <= REQ;
            req_q <= 1'b1;
          end
          REQ: begin
            if (mem.mem_ack_i) begin
              ir      <= mem.mem_data_i;
              pc_held <= pc;
              pc      <= pc + ADDRSIZE'(1);
              valid_q <= 1'b1;
              state   <= HOLD;
              req_q   <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
              to_cnt  <= '0;
`endif
            end
`ifdef IFETCH_TIMEOUT_EN
            else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
              // Give up on this attempt, flag it, and keep requesting the same PC.
              to_cnt <= '0;
              err_q  <= 1'b1;
            end else begin
              to_cnt <= to_cnt + CNT_W'(1);
            end
`endif
          end
          HOLD: begin
            if (!stall_i) begin
              state   <= REQ;
              req_q   <= 1'b1;
              valid_q <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem.mem_req_o  = req_q;
  assign mem.mem_addr_o = pc;
  assign valid_o        = valid_q;
  assign pc_o           = pc_held;
  assign opcode_o       = ir[DATASIZE-1:OPERANDSIZE];
  assign operand_o      = ir[OPERANDSIZE-1:0];

`ifdef IFETCH_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a directed vector table, hand-written reset and timeout
// sequences, then randomized traffic scored against an address-stream model.
module tb_ifetch;

  localparam int DW = 16;
  localparam int OW = 11;
  localparam int AW = 11;
  localparam int TO = 8;

  logic          clk;
  logic          rstn;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic          stall;
  logic [DW-OW-1:0] opcode;
  logic [OW-1:0] operand;
  logic          valid;
  logic [AW-1:0] pc_out;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  ifetch_if #(.DATASIZE(DW), .ADDRSIZE(AW)) mem ();

  ifetch #(
    .DATASIZE(DW), .OPERANDSIZE(OW), .ADDRSIZE(AW), .TIMEOUT(TO)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .mem         (mem),
    .pc_load_i   (pc_load),
    .pc_target_i (pc_target),
    .stall_i     (stall),
    .opcode_o    (opcode),
    .operand_o   (operand),
    .valid_o     (valid),
    .pc_o        (pc_out),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          load;
    logic [AW-1:0] tgt;
    logic          stl;
    logic          ack;
    logic [DW-1:0] data;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic          e_valid;
    logic [DW-1:0] e_instr;
    logic [AW-1:0] e_pc;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [AW-1:0] tg, input logic st,
                       input logic ak, input logic [DW-1:0] dt);
    pc_load        = ld;
    pc_target      = tg;
    stall          = st;
    mem.mem_ack_i  = ak;
    mem.mem_data_i = dt;
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [AW-1:0] e_addr,
                            input logic e_valid, input logic [DW-1:0] e_instr,
                            input logic [AW-1:0] e_pc);
    check({tag, ".req"},   32'(mem.mem_req_o),  32'(e_req));
    check({tag, ".addr"},  32'(mem.mem_addr_o), 32'(e_addr));
    check({tag, ".valid"}, 32'(valid),          32'(e_valid));
    check({tag, ".err"},   32'(err),            32'd0);
    if (e_valid) begin
      check({tag, ".instr"}, 32'({opcode, operand}), 32'(e_instr));
      check({tag, ".pc"},    32'(pc_out),            32'(e_pc));
    end
  endtask

  // Random-phase model: the address the PC should be on, and the instruction
  // (if any) that should currently be offered downstream.
  logic [DW-1:0] mem_img [2048];
  int            exp_addr;
  bit            exp_req;
  bit            exp_valid;
  int            exp_pc;
  int            wait_cnt;

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    rstn = 1'b0;

    //             load tgt     stl ack data      req addr    val instr     pc
    vecs[0]  = '{1'b0, 11'h000, 1'b0, 1'b0, 16'h0000, 1'b1, 11'h000, 1'b0, 16'h0000, 11'h000};
    vecs[1]  = '{1'b0, 11'h000, 1'b0, 1'b1, 16'hA805, 1'b0, 11'h001, 1'b1, 16'hA805, 11'h000};
    vecs[2]  = '{1'b0, 11'h000, 1'b1, 1'b0, 16'h0000, 1'b0, 11'h001, 1'b1, 16'hA805, 11'h000};
    vecs[3]  = '{1'b0, 11'h000, 1'b1, 1'b0, 16'h0000, 1'b0, 11'h001, 1'b1, 16'hA805, 11'h000};
    vecs[4]  = '{1'b0, 11'h000, 1'b1, 1'b0, 16'h0000, 1'b0, 11'h001, 1'b1, 16'hA805, 11'h000};
    vecs[5]  = '{1'b0, 11'h000, 1'b1, 1'b0, 16'h0000, 1'b0, 11'h001, 1'b1, 16'hA805, 11'h000};
    vecs[6]  = '{1'b0, 11'h000, 1'b0, 1'b0, 16'h0000, 1'b1, 11'h001, 1'b0, 16'h0000, 11'h000};
    vecs[7]  = '{1'b0, 11'h000, 1'b0, 1'b1, 16'h1234, 1'b0, 11'h002, 1'b1, 16'h1234, 11'h001};
    vecs[8]  = '{1'b1, 11'h7FF, 1'b1, 1'b0, 16'h0000, 1'b1, 11'h7FF, 1'b0, 16'h0000, 11'h000};
    vecs[9]  = '{1'b0, 11'h000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 11'h000, 1'b1, 16'hFFFF, 11'h7FF};
    vecs[10] = '{1'b0, 11'h000, 1'b0, 1'b0, 16'h0000, 1'b1, 11'h000, 1'b0, 16'h0000, 11'h000};
    vecs[11] = '{1'b1, 11'h040, 1'b0, 1'b1, 16'hBEEF, 1'b1, 11'h040, 1'b0, 16'h0000, 11'h000};
    vecs[12] = '{1'b0, 11'h000, 1'b0, 1'b0, 16'h0000, 1'b1, 11'h040, 1'b0, 16'h0000, 11'h000};
    vecs[13] = '{1'b0, 11'h000, 1'b0, 1'b1, 16'h0801, 1'b0, 11'h041, 1'b1, 16'h0801, 11'h040};
    vecs[14] = '{1'b0, 11'h000, 1'b0, 1'b1, 16'hDEAD, 1'b1, 11'h041, 1'b0, 16'h0000, 11'h000};

    // Reset values appear without needing a clock edge.
    #12;
    check("rst.req",   32'(mem.mem_req_o),         32'd0);
    check("rst.addr",  32'(mem.mem_addr_o),        32'd0);
    check("rst.valid", 32'(valid),                 32'd0);
    check("rst.pc",    32'(pc_out),                32'd0);
    check("rst.instr", 32'({opcode, operand}),     32'd0);
    check("rst.err",   32'(err),                   32'd0);

    @(negedge clk);
    rstn = 1'b1;

    // Directed vectors: inputs applied for one cycle, outputs checked after the edge.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].load, vecs[i].tgt, vecs[i].stl, vecs[i].ack, vecs[i].data);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
    end

    // Reset in the middle of a request, ack present right after release.
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    rstn = 1'b0;
    #1;
    check("midrst.req",   32'(mem.mem_req_o),  32'd0);
    check("midrst.addr",  32'(mem.mem_addr_o), 32'd0);
    check("midrst.valid", 32'(valid),          32'd0);
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 16'hA805);
    @(negedge clk);
    check_outs("postrst.idle", 1'b1, 11'h000, 1'b0, 16'h0000, 11'h000);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check_outs("postrst.wait", 1'b1, 11'h000, 1'b0, 16'h0000, 11'h000);
    drive(1'b0, '0, 1'b0, 1'b1, 16'h5555);
    @(negedge clk);
    check_outs("postrst.fetch", 1'b0, 11'h001, 1'b1, 16'h5555, 11'h000);

    // Leave HOLD and then starve the request of acks.
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    for (int k = 1; k <= 2 * TO + 1; k++) begin
      @(negedge clk);
      check($sformatf("starve%0d.addr", k), 32'(mem.mem_addr_o), 32'h001);
      check($sformatf("starve%0d.req", k),  32'(mem.mem_req_o),  32'd1);
`ifdef IFETCH_TIMEOUT_EN
      check($sformatf("starve%0d.err", k),  32'(err), 32'((k % TO) == 0));
`else
      check($sformatf("starve%0d.err", k),  32'(err), 32'd0);
`endif
    end

    // Randomized traffic against the address-stream model.
    for (int a = 0; a < 2048; a++) mem_img[a] = 16'($urandom);
    rstn = 1'b0;
    @(negedge clk);
    rstn      = 1'b1;
    exp_addr  = 0;
    exp_req   = 1'b0;
    exp_valid = 1'b0;
    exp_pc    = 0;
    wait_cnt  = 0;
    for (int c = 0; c < 1500; c++) begin
      logic          jmp;
      logic [AW-1:0] tgt;
      logic          stl;
      logic          ak;

      check("rnd.req",   32'(mem.mem_req_o),  32'(exp_req));
      check("rnd.addr",  32'(mem.mem_addr_o), 32'(exp_addr));
      check("rnd.valid", 32'(valid),          32'(exp_valid));
      check("rnd.err",   32'(err),            32'd0);
      if (exp_valid) begin
        check("rnd.instr", 32'({opcode, operand}), 32'(mem_img[exp_pc]));
        check("rnd.pc",    32'(pc_out),            32'(exp_pc));
      end

      jmp = ($urandom_range(15) == 0);
      tgt = AW'($urandom_range(2047));
      stl = 1'($urandom_range(1));
      if (exp_req) ak = (wait_cnt >= 3) || ($urandom_range(1) == 1);
      else         ak = ($urandom_range(7) == 0);
      drive(jmp, tgt, stl, ak, exp_req ? mem_img[exp_addr] : 16'($urandom));

      wait_cnt = (exp_req && !ak && !jmp) ? wait_cnt + 1 : 0;
      if (jmp) begin
        exp_addr  = int'(tgt);
        exp_valid = 1'b0;
        exp_req   = 1'b1;
      end else if (exp_req && ak) begin
        exp_valid = 1'b1;
        exp_pc    = exp_addr;
        exp_addr  = (exp_addr + 1) % 2048;
        exp_req   = 1'b0;
      end else if (!exp_req && !exp_valid) begin
        exp_req = 1'b1;
      end else if (exp_valid && !stl) begin
        exp_valid = 1'b0;
        exp_req   = 1'b1;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
